// File: rtl/pipelined_adder.sv
// Valid/ready pipelined adder/subtractor: one WIDTH/STAGES-bit slice of the sum per stage.
// Define PIPELINED_ADDER_FLAGS_EN to add the o_overflow and o_zero result flags.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
`ifdef PIPELINED_ADDER_FLAGS_EN
    ,
    output logic             o_overflow,
    output logic             o_zero
`endif
);
    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];

    logic [STAGES-1:0] ld;
    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] carry_d;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];

    // Stage 0 sees the (possibly inverted) input operands; later stages see their predecessor.
    always_comb begin
        src_valid[0] = i_valid;
        src_a[0]     = i_a;
        src_b[0]     = i_sub ? ~i_b : i_b;
        src_sum[0]   = '0;
        src_c[0]     = i_carry ^ i_sub;
        for (int k = 1; k < STAGES; k++) begin
            src_valid[k] = valid_q[k-1];
            src_a[k]     = a_q[k-1];
            src_b[k]     = b_q[k-1];
            src_sum[k]   = sum_q[k-1];
            src_c[k]     = carry_q[k-1];
        end
    end

    always_comb begin
        logic [SW:0] part;
        part = '0;
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k] = src_sum[k];
            part = {1'b0, src_a[k][k*SW +: SW]} + {1'b0, src_b[k][k*SW +: SW]}
                 + {{SW{1'b0}}, src_c[k]};
            sum_d[k][k*SW +: SW] = part[SW-1:0];
            carry_d[k]           = part[SW];
        end
    end

    // Load enables ripple back from the output so a stalled pipe still fills its bubbles.
    always_comb begin
        logic nxt;
        nxt = i_ready;
        ld  = '0;
        for (int k = int'(LAST); k >= 0; k--) begin
            ld[k] = ~valid_q[k] | nxt;
            nxt   = ld[k];
        end
    end

    assign o_ready = ld[0] & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        a_q[k]     <= src_a[k];
                        b_q[k]     <= src_b[k];
                        sum_q[k]   <= sum_d[k];
                        carry_q[k] <= carry_d[k];
                    end
                end
            end
        end
    end

    assign o_valid = valid_q[LAST];
    assign o_sum   = sum_q[LAST];
    assign o_carry = carry_q[LAST];

`ifdef PIPELINED_ADDER_FLAGS_EN
    logic overflow_q;
    logic zero_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else if (ld[LAST] && src_valid[LAST]) begin
            // Same-sign operands producing a differently-signed result.
            overflow_q <= (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
                          (sum_d[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
            zero_q     <= (sum_d[LAST] == '0);
        end
    end

    assign o_overflow = overflow_q;
    assign o_zero     = zero_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed 8-bit/2-stage vectors and randomized 32-bit/4-stage traffic.
module tb_pipelined_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       v8, ir8, c8, sub8, ordy8, ov8, oc8;
    logic [7:0] a8, b8, s8;
    logic        v32, ir32, c32, sub32, ordy32, ov32, oc32;
    logic [31:0] a32, b32, s32;
`ifdef PIPELINED_ADDER_FLAGS_EN
    logic ovf8, z8, ovf32, z32;
`endif

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(ordy8),
        .i_a(a8), .i_b(b8), .i_carry(c8), .i_sub(sub8),
        .o_valid(ov8), .i_ready(ir8), .o_sum(s8), .o_carry(oc8)
`ifdef PIPELINED_ADDER_FLAGS_EN
        , .o_overflow(ovf8), .o_zero(z8)
`endif
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(ordy32),
        .i_a(a32), .i_b(b32), .i_carry(c32), .i_sub(sub32),
        .o_valid(ov32), .i_ready(ir32), .o_sum(s32), .o_carry(oc32)
`ifdef PIPELINED_ADDER_FLAGS_EN
        , .o_overflow(ovf32), .o_zero(z32)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       cin, sub;
        logic [7:0] sum;
        logic       carry, ovf, zero;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        carry, ovf, zero;
    } exp_t;

    // Reference: plain add, or subtraction as 2^32 + a - b - borrow; overflow from true signed value.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic c, input logic sub);
        exp_t        m;
        logic [32:0] r;
        longint      sr;
        if (!sub) begin
            r  = {1'b0, a} + {1'b0, b} + 33'(c);
            sr = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        end else begin
            r  = {1'b1, a} - {1'b0, b} - 33'(c);
            sr = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        end
        m.sum   = r[31:0];
        m.carry = r[32];
        m.ovf   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        m.zero  = (r[31:0] == 32'h0);
        return m;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[8];
    int   acc;
    int   outs[$];
    int   out_cyc[$];
    exp_t q[$];
    exp_t e;
    logic [31:0] prev_sum;
    logic        prev_carry;
    logic        prev_stall;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        v8 = 0; ir8 = 1; c8 = 0; sub8 = 0; a8 = 0; b8 = 0;
        v32 = 0; ir32 = 1; c32 = 0; sub32 = 0; a32 = 0; b32 = 0;
        #2;
        chk("rst_valid8", ov8, 0);
        chk("rst_ready8", ordy8, 0);
        chk("rst_valid32", ov32, 0);
        chk("rst_ready32", ordy32, 0);
        #15 rst_n = 1'b1;
        #1;
        chk("post_rst_ready8", ordy8, 1);
        chk("post_rst_valid8", ov8, 0);
        chk("post_rst_sum8", s8, 0);
        chk("post_rst_carry8", oc8, 0);
        chk("post_rst_ready32", ordy32, 1);
        @(posedge clk); #1;

        // Single operations, exact latency of two cycles.
        for (int i = 0; i < 8; i++) begin
            a8 = vecs[i].a; b8 = vecs[i].b; c8 = vecs[i].cin; sub8 = vecs[i].sub; v8 = 1;
            #1 chk("vec_ready", ordy8, 1);
            @(posedge clk); #1;
            v8 = 0;
            #1 chk("vec_latency", ov8, 0);
            @(posedge clk); #1;
            chk("vec_valid", ov8, 1);
            chk("vec_sum", s8, vecs[i].sum);
            chk("vec_carry", oc8, vecs[i].carry);
`ifdef PIPELINED_ADDER_FLAGS_EN
            chk("vec_ovf", ovf8, vecs[i].ovf);
            chk("vec_zero", z8, vecs[i].zero);
`endif
            @(posedge clk); #1;
        end

        // Back-to-back issue into a stalled output, then release.
        acc = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            ir8 = (cyc >= 5);
            if (acc < 4) begin
                v8 = 1; a8 = 8'(acc + 1); b8 = 8'(acc + 1); c8 = 0; sub8 = 0;
            end else begin
                v8 = 0;
            end
            #1;
            if (cyc >= 2 && cyc < 5) begin
                chk("stall_ready", ordy8, 0);
                chk("stall_valid", ov8, 1);
                chk("stall_sum", s8, 8'h02);
            end
            if (ov8 && ir8) begin
                outs.push_back(int'(s8));
                out_cyc.push_back(cyc);
            end
            if (v8 && ordy8) acc++;
            @(posedge clk); #1;
        end
        v8 = 0; ir8 = 1;
        chk("stall_accepted", acc, 4);
        chk("stall_out_count", outs.size(), 4);
        for (int i = 0; i < outs.size(); i++) begin
            chk("stall_order", outs[i], 2 * (i + 1));
            chk("stall_rate", out_cyc[i], out_cyc[0] + i);
        end

        // Reset pulse with two operations in flight.
        v8 = 1; a8 = 8'h11; b8 = 8'h22; c8 = 0; sub8 = 0;
        @(posedge clk); #1;
        a8 = 8'h33; b8 = 8'h44;
        @(posedge clk); #1;
        v8 = 0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ov8, 0);
        chk("midrst_ready", ordy8, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 chk("midrst_release_ready", ordy8, 1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_no_stale", ov8, 0);
            chk("midrst_sum_zero", s8, 0);
            @(posedge clk); #1;
        end
        v8 = 1; a8 = 8'h09; b8 = 8'h03;
        @(posedge clk); #1;
        v8 = 0;
        #1 chk("midrst_lat1", ov8, 0);
        @(posedge clk); #1;
        chk("midrst_valid_out", ov8, 1);
        chk("midrst_sum", s8, 8'h0C);
        chk("midrst_carry", oc8, 0);
        @(posedge clk); #1;

        // Randomized traffic on the 32-bit, 4-stage instance.
        prev_stall = 0; prev_sum = 0; prev_carry = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v32   = ($urandom_range(0, 9) < 7);
            ir32  = ($urandom_range(0, 9) < 6);
            a32   = rnd32();
            b32   = rnd32();
            c32   = 1'($urandom_range(0, 1));
            sub32 = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                chk("rnd_hold_sum", s32, prev_sum);
                chk("rnd_hold_carry", oc32, prev_carry);
            end
            if (ov32 && ir32) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious", ov32, 0);
                end else begin
                    e = q.pop_front();
                    chk("rnd_sum", s32, e.sum);
                    chk("rnd_carry", oc32, e.carry);
`ifdef PIPELINED_ADDER_FLAGS_EN
                    chk("rnd_ovf", ovf32, e.ovf);
                    chk("rnd_zero", z32, e.zero);
`endif
                end
            end
            if (v32 && ordy32) q.push_back(model(a32, b32, c32, sub32));
            prev_stall = ov32 && !ir32;
            prev_sum   = s32;
            prev_carry = oc32;
            @(posedge clk); #1;
        end
        v32 = 0; ir32 = 1;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            #1;
            if (ov32) begin
                e = q.pop_front();
                chk("drain_sum", s32, e.sum);
                chk("drain_carry", oc32, e.carry);
            end
            @(posedge clk); #1;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk); #1;
        chk("drain_idle", ov32, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits (>= 2).
REQ-002 Parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES; slice width SW = WIDTH/STAGES.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_valid  input  1  upstream operand set valid.
REQ-006 o_ready  output  1  block can accept an operand set this cycle.
REQ-007 i_a  input  WIDTH  operand A.
REQ-008 i_b  input  WIDTH  operand B.
REQ-009 i_carry  input  1  carry-in (add) / borrow-in (sub, 1 = borrow).
REQ-010 i_sub  input  1  0 = A+B+cin, 1 = A-B-borrow.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  downstream accepts result.
REQ-013 o_sum  output  WIDTH  result.
REQ-014 o_carry  output  1  add: carry-out; sub: 1 = no borrow (two's-complement carry).

Function
REQ-015 Effective operands: B' = i_sub ? ~i_b : i_b; cin' = i_carry XOR i_sub.
REQ-016 Result SHALL equal the low WIDTH bits of A + B' + cin', o_carry = bit WIDTH; WIDTH+1-bit arithmetic, no saturation.
REQ-017 Stage k (0..STAGES-1) SHALL add slice k of A and B' using the carry registered by stage k-1 (stage 0 uses cin'), registering sum slice, carry and the still-unused upper operand slices.
REQ-018 Each stage holds a valid bit; transfer in = i_valid & o_ready; transfer out = o_valid & i_ready.
REQ-019 Stage k SHALL load when empty or when stage k+1 (or the output for the last stage) accepts in the same cycle; otherwise it holds all contents.
REQ-020 o_ready SHALL equal (stage 0 empty) OR (stage 0 advances this cycle); combinational from i_ready allowed.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to o_valid with no stall; throughput one result per cycle with i_ready held high.
REQ-022 Results SHALL leave in acceptance order; no loss or duplication under any i_ready pattern.
REQ-023 o_sum/o_carry SHALL remain stable while o_valid=1 and i_ready=0.
REQ-024 Bubbles (i_valid=0) SHALL be collapsed: a stalled full stage accepts a predecessor's entry as soon as it advances.
REQ-025 Simultaneous in/out transfer with all stages full SHALL be accepted (no throughput loss).

Reset
REQ-026 i_rst_n low SHALL immediately clear all stage valid bits; o_valid = 0, o_ready = 0 during reset, 1 in the first cycle after release.
REQ-027 Datapath registers need not reset; o_sum, o_carry SHALL read 0 while o_valid = 0 after reset until the first result.
REQ-028 Reset mid-operation SHALL discard all in-flight results; none appear after release.

Configuration
REQ-029 Macro PIPELINED_ADDER_FLAGS_EN defined: outputs o_overflow (signed overflow of the WIDTH-bit result) and o_zero (o_sum == 0) exist, registered alongside o_sum, 0 after reset, held under stall.
REQ-030 Macro undefined: those ports and their logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, STAGES=2, i_ready=1 unless stated)
REQ-031 A=0xFF, B=0x01, cin=0, sub=0 -> 2 cycles later o_sum=0x00, o_carry=1, o_zero=1 (flags on).
REQ-032 A=0x05, B=0x07, borrow=0, sub=1 -> o_sum=0xFE, o_carry=0; A=0x07, B=0x05 -> 0x02, o_carry=1.
REQ-033 A=0x7F, B=0x01, add -> o_sum=0x80, o_overflow=1; A=0x80, B=0x01, sub -> 0x7F, o_overflow=1.
REQ-034 Issue 4 back-to-back ops (1+1, 2+2, 3+3, 4+4), hold i_ready=0 for 5 cycles -> o_ready drops after 2 accepted, 0x02 held stable; release -> 0x02,0x04,0x06,0x08 in order, one per cycle.
REQ-035 Pulse i_rst_n low for 1 cycle with 2 ops in flight -> o_valid=0 immediately, no stale results after release, next op returns correctly at latency 2.
REQ-036 Random stimulus, random i_valid/i_ready, WIDTH=32/STAGES=4 -> every result matches reference model, order preserved.
